// File: rtl/alu_exec_unit.sv
// Execute stage of the single-cycle MIPS datapath: ALU-control decode, 32-bit ALU
// and branch AND gate, with every output registered for one clock of latency.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             branch,
    output logic             out_valid,
    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             branch_taken
);

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SLL  = 4'b0011;
    localparam logic [3:0] CTL_SRL  = 4'b0100;
    localparam logic [3:0] CTL_SRA  = 4'b0101;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_SLTU = 4'b1000;
    localparam logic [3:0] CTL_NOR  = 4'b1100;
    localparam logic [3:0] CTL_XOR  = 4'b1101;
    localparam logic [3:0] CTL_ILL  = 4'b1111;

    logic [3:0]       ctl_next;
    logic             illegal_next;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt_signed;
    logic             lt_unsigned;
    logic [WIDTH-1:0] result_next;
    logic             overflow_next;
    logic             zero_next;

    always_comb begin
        ctl_next     = CTL_ADD;
        illegal_next = 1'b0;
        case (alu_op)
            2'b00: ctl_next = CTL_ADD;
            2'b01: ctl_next = CTL_SUB;
            2'b11: ctl_next = CTL_SLT;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: ctl_next = CTL_ADD;
                    6'b100010, 6'b100011: ctl_next = CTL_SUB;
                    6'b100100: ctl_next = CTL_AND;
                    6'b100101: ctl_next = CTL_OR;
                    6'b100110: ctl_next = CTL_XOR;
                    6'b100111: ctl_next = CTL_NOR;
                    6'b101010: ctl_next = CTL_SLT;
                    6'b101011: ctl_next = CTL_SLTU;
                    6'b000000: ctl_next = CTL_SLL;
                    6'b000010: ctl_next = CTL_SRL;
                    6'b000011: ctl_next = CTL_SRA;
                    default: begin
                        ctl_next     = CTL_ILL;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            default: ctl_next = CTL_ADD;
        endcase
    end

    assign sum         = a + b;
    assign diff        = a - b;
    assign add_ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    // Shifts operate on b only; a is the rs field, which shift instructions don't use.
    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        case (ctl_next)
            CTL_ADD: begin
                result_next   = sum;
                overflow_next = add_ovf;
            end
            CTL_SUB: begin
                result_next   = diff;
                overflow_next = sub_ovf;
            end
            CTL_AND:  result_next = a & b;
            CTL_OR:   result_next = a | b;
            CTL_XOR:  result_next = a ^ b;
            CTL_NOR:  result_next = ~(a | b);
            CTL_SLT:  result_next = {{(WIDTH-1){1'b0}}, lt_signed};
            CTL_SLTU: result_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
            CTL_SLL:  result_next = b << shamt;
            CTL_SRL:  result_next = b >> shamt;
            CTL_SRA:  result_next = $signed(b) >>> shamt;
            default:  result_next = '0;
        endcase
    end

    assign zero_next = (result_next == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            alu_ctl      <= 4'b0000;
            result       <= '0;
            zero         <= 1'b0;
            overflow     <= 1'b0;
            illegal      <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_ctl      <= ctl_next;
                result       <= result_next;
                zero         <= zero_next;
                overflow     <= overflow_next;
                illegal      <= illegal_next;
                branch_taken <= branch & zero_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results are queued as each operation
// is driven and popped/compared once the registered outputs appear.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic        branch;
    logic        out_valid;
    logic [3:0]  alu_ctl;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;
    logic        branch_taken;

    typedef struct {
        string       name;
        logic [3:0]  ctl;
        logic [31:0] res;
        logic        zr;
        logic        ovf;
        logic        ill;
        logic        bt;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op), .funct(funct),
        .shamt(shamt), .a(a), .b(b), .branch(branch), .out_valid(out_valid),
        .alu_ctl(alu_ctl), .result(result), .zero(zero), .overflow(overflow),
        .illegal(illegal), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic ov, input exp_t e);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
        chk({tag, ".alu_ctl"}, {28'b0, alu_ctl}, {28'b0, e.ctl});
        chk({tag, ".result"}, result, e.res);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, e.zr});
        chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, e.ovf});
        chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, e.ill});
        chk({tag, ".branch_taken"}, {31'b0, branch_taken}, {31'b0, e.bt});
    endtask

    // Drive one valid operation, queue its expectation, then compare one edge later.
    task automatic step(input string name, input logic [1:0] op, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [31:0] va, input logic [31:0] vb,
                        input logic br, input logic [3:0] e_ctl, input logic [31:0] e_res,
                        input logic e_ovf, input logic e_ill, input logic e_bt);
        exp_t e;
        e.name = name; e.ctl = e_ctl; e.res = e_res; e.zr = (e_res == 32'h0);
        e.ovf = e_ovf; e.ill = e_ill; e.bt = e_bt;
        sb.push_back(e);
        in_valid = 1'b1; alu_op = op; funct = fn; shamt = sh; a = va; b = vb; branch = br;
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", name);
        end else begin
            e = sb.pop_front();
            chk_outputs(e.name, 1'b1, e);
            last = e;
        end
    endtask

    initial begin
        exp_t zeros;
        zeros.name = "reset"; zeros.ctl = 4'h0; zeros.res = 32'h0; zeros.zr = 1'b0;
        zeros.ovf = 1'b0; zeros.ill = 1'b0; zeros.bt = 1'b0;

        rst = 1'b0; in_valid = 1'b1; alu_op = 2'b10; funct = 6'b100000;
        shamt = 5'd0; a = 32'd5; b = 32'd7; branch = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk_outputs("reset", 1'b0, zeros);
        end
        rst = 1'b1;

        step("add_rel", 2'b10, 6'b100000, 5'd0, 32'd5, 32'd7, 1'b0, 4'b0010, 32'd12, 1'b0, 1'b0, 1'b0);
        step("beq_taken", 2'b01, 6'b000000, 5'd0, 32'h1234, 32'h1234, 1'b1, 4'b0110, 32'h0, 1'b0, 1'b0, 1'b1);
        step("beq_not", 2'b01, 6'b000000, 5'd0, 32'h1234, 32'h1235, 1'b1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        step("and", 2'b10, 6'b100100, 5'd0, 32'hF0F0_0000, 32'h0FF0_FFFF, 1'b0, 4'b0000, 32'h00F0_0000, 1'b0, 1'b0, 1'b0);
        step("or", 2'b10, 6'b100101, 5'd0, 32'hF0F0_0000, 32'h0FF0_FFFF, 1'b0, 4'b0001, 32'hFFF0_FFFF, 1'b0, 1'b0, 1'b0);
        step("xor", 2'b10, 6'b100110, 5'd0, 32'hF0F0_0000, 32'h0FF0_FFFF, 1'b0, 4'b1101, 32'hFF00_FFFF, 1'b0, 1'b0, 1'b0);
        step("nor", 2'b10, 6'b100111, 5'd0, 32'hF0F0_0000, 32'h0FF0_FFFF, 1'b0, 4'b1100, 32'h000F_0000, 1'b0, 1'b0, 1'b0);
        step("slt", 2'b10, 6'b101010, 5'd0, 32'hF0F0_0000, 32'h0FF0_FFFF, 1'b0, 4'b0111, 32'h1, 1'b0, 1'b0, 1'b0);
        step("sltu", 2'b10, 6'b101011, 5'd0, 32'hF0F0_0000, 32'h0FF0_FFFF, 1'b1, 4'b1000, 32'h0, 1'b0, 1'b0, 1'b1);
        step("sll", 2'b10, 6'b000000, 5'd4, 32'hDEAD_BEEF, 32'h8000_0010, 1'b0, 4'b0011, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        step("srl", 2'b10, 6'b000010, 5'd4, 32'hDEAD_BEEF, 32'h8000_0010, 1'b0, 4'b0100, 32'h0800_0001, 1'b0, 1'b0, 1'b0);
        step("sra", 2'b10, 6'b000011, 5'd4, 32'hDEAD_BEEF, 32'h8000_0010, 1'b0, 4'b0101, 32'hF800_0001, 1'b0, 1'b0, 1'b0);
        step("sra_sh0", 2'b10, 6'b000011, 5'd0, 32'h0, 32'h8000_0010, 1'b0, 4'b0101, 32'h8000_0010, 1'b0, 1'b0, 1'b0);
        step("add_ovf", 2'b00, 6'b111111, 5'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'b0010, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        step("sub_ovf", 2'b10, 6'b100010, 5'd0, 32'h8000_0000, 32'h1, 1'b0, 4'b0110, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        step("add_wrap", 2'b00, 6'b000000, 5'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'b0010, 32'h0, 1'b0, 1'b0, 1'b0);
        step("addu", 2'b10, 6'b100001, 5'd0, 32'd100, 32'hFFFF_FFF6, 1'b0, 4'b0010, 32'd90, 1'b0, 1'b0, 1'b0);
        step("subu", 2'b10, 6'b100011, 5'd0, 32'd3, 32'd10, 1'b0, 4'b0110, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b0);
        step("slti", 2'b11, 6'b100100, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'b0111, 32'h1, 1'b0, 1'b0, 1'b0);
        step("illegal", 2'b10, 6'b111111, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 4'b1111, 32'h0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0; alu_op = 2'(i); funct = 6'b100000 + 6'(i);
            shamt = 5'(i + 1); a = $urandom; b = $urandom; branch = i[0];
            @(posedge clk); #1;
            chk_outputs("hold", 1'b0, last);
        end

        step("pre_rst", 2'b00, 6'b000000, 5'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'b0010, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0; in_valid = 1'b1; alu_op = 2'b10; funct = 6'b111111; branch = 1'b1;
        @(posedge clk); #1;
        chk_outputs("rst_prio", 1'b0, zeros);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage block of the single-cycle MIPS datapath.
- Merges three functions:
  - ALU-control decoding from the 2-bit main-control ALUOp plus the instruction funct field.
  - The 32-bit ALU.
  - The branch AND gate, which combines the Branch control flag with the ALU zero flag.
- All outputs are registered, so results appear one clock after the operands are presented.
- Consumers: data memory (address), register write-back mux, and the PC-source mux.

Parameters:
- WIDTH, 32: operand and result width.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous reset, active-low.
- in_valid, input, 1: operands and controls are valid this cycle.
- alu_op, input, 2: ALUOp from main control.
- funct, input, 6: instruction[5:0].
- shamt, input, 5: instruction[10:6].
- a, input, WIDTH: register readData1.
- b, input, WIDTH: ALUSrc-mux output (readData2 or sign-extended immediate).
- branch, input, 1: Branch flag from main control.
- out_valid, output, 1: registered copy of in_valid.
- alu_ctl, output, 4: decoded ALU operation code.
- result, output, WIDTH: ALU result.
- zero, output, 1: result == 0.
- overflow, output, 1: signed overflow on ADD/SUB.
- illegal, output, 1: unsupported funct when alu_op = 10.
- branch_taken, output, 1: branch AND zero.

Behaviour:
- Reset: when rst = 0 at a rising clk edge, every output clears to 0 on that edge: out_valid, alu_ctl = 0000, result = 0, zero, overflow, illegal, branch_taken. Reset has priority over in_valid.
- Latency: 1 clock.
  - On each rising edge with rst = 1 and in_valid = 1, register alu_ctl, result, zero, overflow, illegal and branch_taken, all computed combinationally from the current inputs.
  - On edges with in_valid = 0, hold all outputs except out_valid, which loads 0.
- ALU control decode (alu_ctl):
  - alu_op 00 → 0010 ADD (lw/sw/addi).
  - alu_op 01 → 0110 SUB (beq).
  - alu_op 11 → 0111 SLT (slti).
  - alu_op 10 → decode by funct:
    - 100000 and 100001 → 0010 ADD.
    - 100010 and 100011 → 0110 SUB.
    - 100100 → 0000 AND.
    - 100101 → 0001 OR.
    - 100110 → 1101 XOR.
    - 100111 → 1100 NOR.
    - 101010 → 0111 SLT.
    - 101011 → 1000 SLTU.
    - 000000 → 0011 SLL.
    - 000010 → 0100 SRL.
    - 000011 → 0101 SRA.
    - Any other funct → alu_ctl 1111, illegal = 1, result = 0.
  - illegal = 0 for every other alu_op/funct combination.
- ALU operations (modulo 2^WIDTH unless noted):
  - ADD: a + b.
  - SUB: a − b.
  - AND, OR, XOR: bitwise on a and b.
  - NOR: ~(a | b).
  - SLT: 1 if signed a < signed b, else 0.
  - SLTU: 1 if unsigned a < unsigned b, else 0.
  - SLL: b << shamt.
  - SRL: b >> shamt, logical.
  - SRA: b >>> shamt, arithmetic (sign-filled).
  - Shifts ignore a; shamt = 0 passes b unchanged.
- zero: 1 when the result being registered is all zeros, including the illegal case.
- overflow:
  - ADD: 1 when a and b have the same sign and the sum's sign differs.
  - SUB: 1 when a and b have different signs and the difference's sign differs from a.
  - 0 for all other operations.
  - Wrap-around still produces the truncated result; overflow is flag only, no trap.
- branch_taken: branch & zero, evaluated on the same-cycle combinational zero and registered together with it. branch = 1 with a non-SUB op is still ANDed literally.
- Simultaneous events: rst = 0 with in_valid = 1 → reset wins.
- Implementation constraints: no internal state beyond the output registers. No X propagation; all case statements carry defaults.

Test Plan:
- Reset: drive rst = 0 for 2 cycles with in_valid = 1, alu_op = 10, funct = 100000 → all outputs 0.
  - Release with a = 5, b = 7 → next edge: result = 12, alu_ctl = 0010, zero = 0, out_valid = 1.
- beq taken: alu_op = 01, branch = 1, a = b = 0x1234 → result = 0, zero = 1, branch_taken = 1.
  - Same with b = 0x1235 → result = 0xFFFFFFFF, branch_taken = 0.
- Logic and SLT via funct, a = 0xF0F0_0000, b = 0x0FF0_FFFF:
  - AND → 0x00F0_0000.
  - OR → 0xFFF0_FFFF.
  - NOR → 0x000F_0000.
  - SLT → 1 (a negative).
  - SLTU → 0.
- Shifts, b = 0x8000_0010, shamt = 4:
  - SLL → 0x0000_0100.
  - SRL → 0x0800_0001.
  - SRA → 0xF800_0001.
- Overflow:
  - ADD 0x7FFF_FFFF + 1 → result 0x8000_0000, overflow = 1.
  - SUB 0x8000_0000 − 1 → 0x7FFF_FFFF, overflow = 1.
  - ADD 0xFFFF_FFFF + 1 → 0, zero = 1, overflow = 0.
- Illegal and hold:
  - alu_op = 10, funct = 111111 → alu_ctl = 1111, illegal = 1, result = 0.
  - Then in_valid = 0 for 3 cycles with changing inputs → outputs hold, out_valid = 0.
